// File: rtl/prbs_transmitter.sv
// PRBS7 (XNOR form, x^7+x^6+1) serial bit source for the optical link TX path.
// Produces a checker sync pulse per enable, a programmable bit rate and controlled error injection.
module prbs_transmitter #(
  parameter int         CLK_DIV = 100,
  parameter logic [6:0] SEED    = 7'h00,
  parameter int         PER_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             err_inject_en,
  input  logic [PER_W-1:0] err_period,
  input  logic             inject_single,
  output logic             bit_out,
  output logic             bit_strobe,
  output logic             sync_out,
  output logic [31:0]      bits_sent,
  output logic [31:0]      errors_injected
);

  // All-ones is the XNOR lock-up state, so it is never accepted as a seed.
  localparam logic [6:0]  SEED_OK  = (SEED == 7'h7F) ? 7'h00 : SEED;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [6:0]       lfsr;
  logic [15:0]      div_cnt;
  logic [PER_W-1:0] err_cnt;
  logic [2:0]       supp_cnt;
  logic             pending;
  logic             enable_q;

  logic rise;
  logic tick;
  logic suppressed;
  logic live_tick;
  logic per_active;
  logic per_hit;
  logic sgl_hit;
  logic flip;
  logic nb;

  assign rise       = enable & ~enable_q;
  assign tick       = enable & enable_q & (div_cnt == DIV_LAST);
  assign suppressed = (supp_cnt != 3'd0);
  assign live_tick  = tick & ~suppressed;
  assign per_active = err_inject_en & (err_period != '0);
  // >= rather than == so a shortened period takes effect on the very next bit.
  assign per_hit    = live_tick & per_active & (err_cnt >= (err_period - PER_W'(1)));
  assign sgl_hit    = live_tick & (pending | inject_single);
  assign flip       = per_hit | sgl_hit;
  assign nb         = ~(lfsr[6] ^ lfsr[5]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr            <= SEED_OK;
      div_cnt         <= '0;
      err_cnt         <= '0;
      supp_cnt        <= '0;
      pending         <= 1'b0;
      enable_q        <= 1'b0;
      bit_out         <= 1'b0;
      bit_strobe      <= 1'b0;
      sync_out        <= 1'b0;
      bits_sent       <= '0;
      errors_injected <= '0;
    end else begin
      enable_q   <= enable;
      sync_out   <= rise;
      bit_strobe <= tick;

      // Holding the divider at 0 on the enable edge puts the first bit CLK_DIV cycles after sync.
      if (!enable || rise || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end

      if (rise) begin
        supp_cnt <= 3'd7;
      end else if (tick && suppressed) begin
        supp_cnt <= supp_cnt - 3'd1;
      end

      if (!per_active) begin
        err_cnt <= '0;
      end else if (live_tick) begin
        err_cnt <= per_hit ? '0 : err_cnt + PER_W'(1);
      end

      if (live_tick) begin
        pending <= 1'b0;
      end else if (inject_single) begin
        pending <= 1'b1;
      end

      // The register always advances with the clean bit; only the serial output is corrupted.
      if (tick) begin
        lfsr      <= {lfsr[5:0], nb};
        bit_out   <= nb ^ flip;
        bits_sent <= bits_sent + 32'd1;
        if (flip) begin
          errors_injected <= errors_injected + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_transmitter.sv
// Bench for prbs_transmitter: reference PRBS built from the bit recurrence, injection rules
// modelled per transmitted bit, expected bits flowing through a scoreboard queue.
module tb_prbs_transmitter;
  localparam int CLK_DIV  = 4;
  localparam int PER_W    = 24;
  localparam int MAX_BITS = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic             err_inject_en = 1'b0;
  logic [PER_W-1:0] err_period = '0;
  logic             inject_single = 1'b0;
  logic             bit_out;
  logic             bit_strobe;
  logic             sync_out;
  logic [31:0]      bits_sent;
  logic [31:0]      errors_injected;

  prbs_transmitter #(.CLK_DIV(CLK_DIV), .SEED(7'h00), .PER_W(PER_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_inject_en(err_inject_en),
    .err_period(err_period), .inject_single(inject_single), .bit_out(bit_out),
    .bit_strobe(bit_strobe), .sync_out(sync_out), .bits_sent(bits_sent),
    .errors_injected(errors_injected)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic       ref_seq [0:MAX_BITS+6];
  logic       obs [1:MAX_BITS];
  logic [0:0] exp_q [$];
  logic       last_exp;
  int         ref_n, since_en, unsupp, per_p, exp_sent, exp_err;
  bit         single_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (bit %0d)", tag, got, exp, ref_n);
    end
  endtask

  task automatic model_reset(input logic [6:0] seed, input int per);
    for (int i = 0; i < 7; i++) ref_seq[i] = seed[6-i];
    for (int k = 7; k < MAX_BITS + 7; k++) ref_seq[k] = ~(ref_seq[k-7] ^ ref_seq[k-6]);
    ref_n = 0; since_en = 0; unsupp = 0; exp_sent = 0; exp_err = 0;
    single_req = 1'b0; per_p = per; last_exp = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_bit();
    bit flip;
    flip = 1'b0;
    ref_n++;
    since_en++;
    if (since_en > 7) begin
      unsupp++;
      if (per_p != 0 && (unsupp % per_p) == 0) flip = 1'b1;
      if (single_req) begin
        flip = 1'b1;
        single_req = 1'b0;
      end
    end
    exp_sent++;
    if (flip) exp_err++;
    exp_q.push_back(ref_seq[ref_n+6] ^ flip);
  endtask

  task automatic do_reset(input int per, input bit en_inj);
    rst = 1'b0; enable = 1'b0; inject_single = 1'b0;
    err_inject_en = en_inj; err_period = PER_W'(per);
    repeat (3) @(negedge clk);
    check("rst_bits_sent", bits_sent, 32'd0);
    check("rst_errors", errors_injected, 32'd0);
    check("rst_flags", {29'd0, bit_out, bit_strobe, sync_out}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    model_reset(7'h00, en_inj ? per : 0);
  endtask

  task automatic enable_on();
    enable = 1'b1;
    @(negedge clk);
    check("sync_pulse", {31'd0, sync_out}, 32'd1);
    since_en = 0;
  endtask

  task automatic disable_for(input int cycles);
    int strobes, changes;
    strobes = 0; changes = 0;
    enable = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bit_strobe) strobes++;
      if (bit_out !== last_exp) changes++;
    end
    check("idle_strobes", 32'(strobes), 32'd0);
    check("idle_bit_hold", 32'(changes), 32'd0);
  endtask

  // Runs n bits; inject_single is pulsed in the first cycle of absolute bit inj_bit.
  task automatic run_bits(input int n, input int inj_bit);
    int gap, syncs;
    logic [0:0] e;
    for (int b = 0; b < n; b++) begin
      gap = 0; syncs = 0;
      if (ref_n + 1 == inj_bit) single_req = 1'b1;
      do begin
        inject_single = (gap == 0 && ref_n + 1 == inj_bit);
        @(negedge clk);
        gap++;
        if (sync_out) syncs++;
      end while (!bit_strobe && gap < 3 * CLK_DIV);
      inject_single = 1'b0;
      check("strobe_gap", 32'(gap), 32'(CLK_DIV));
      check("extra_sync", 32'(syncs), 32'd0);
      model_bit();
      e = exp_q.pop_front();
      last_exp = e[0];
      check("bit_out", {31'd0, bit_out}, {31'd0, e[0]});
      if (ref_n <= MAX_BITS) obs[ref_n] = bit_out;
    end
    check("bits_sent", bits_sent, 32'(exp_sent));
    check("errors_injected", errors_injected, 32'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] first8;
    int per_r;
    first8 = 8'b1111_1101;

    // Startup sequence from SEED
    do_reset(0, 1'b0);
    enable_on();
    run_bits(8, 0);
    for (int k = 1; k <= 8; k++) check("first8", {31'd0, obs[k]}, {31'd0, first8[8-k]});
    check("first8_count", bits_sent, 32'd8);

    // Two full periods, clean
    run_bits(246, 0);
    for (int k = 1; k <= 127; k++) check("period127", {31'd0, obs[k+127]}, {31'd0, obs[k]});
    check("clean_errors", errors_injected, 32'd0);

    // Periodic injection every 10 bits
    do_reset(10, 1'b1);
    enable_on();
    run_bits(107, 0);
    for (int k = 1; k <= 107; k++)
      check("flip_pos", {31'd0, obs[k] ^ ref_seq[k+6]}, {31'd0, (k >= 17 && (k - 17) % 10 == 0)});
    check("periodic_count", errors_injected, 32'd10);

    // Single injection inside the suppression window lands on bit 8
    do_reset(0, 1'b0);
    enable_on();
    run_bits(10, 3);
    check("single_bit8", {31'd0, obs[8] ^ ref_seq[14]}, 32'd1);
    check("single_count", errors_injected, 32'd1);

    // Single coinciding with a periodic hit flips once
    do_reset(10, 1'b1);
    enable_on();
    run_bits(20, 17);
    check("coincide_count", errors_injected, 32'd1);

    // Pause and resume: sequence continues, new window suppresses bits 21..27
    do_reset(3, 1'b1);
    enable_on();
    run_bits(20, 0);
    disable_for(50);
    enable_on();
    run_bits(7, 22);
    for (int k = 21; k <= 27; k++) check("resume_clean", {31'd0, obs[k] ^ ref_seq[k+6]}, 32'd0);
    check("resume_count", errors_injected, 32'd4);
    run_bits(5, 0);

    // Asynchronous reset two cycles into a bit
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_bits_sent", bits_sent, 32'd0);
    check("async_errors", errors_injected, 32'd0);
    check("async_flags", {29'd0, bit_out, bit_strobe, sync_out}, 32'd0);
    @(negedge clk);
    enable = 1'b0; err_inject_en = 1'b0; err_period = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset(7'h00, 0);
    enable_on();
    run_bits(8, 0);
    for (int k = 1; k <= 8; k++) check("restart8", {31'd0, obs[k]}, {31'd0, first8[8-k]});

    // Randomized segments with pauses and single requests
    for (int r = 0; r < 3; r++) begin
      per_r = $urandom_range(1, 12);
      do_reset(per_r, 1'b1);
      enable_on();
      for (int s = 0; s < 5; s++) begin
        run_bits($urandom_range(5, 25), ref_n + $urandom_range(1, 12));
        disable_for($urandom_range(3, 20));
        enable_on();
      end
      run_bits(10, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
